boot_loader_ctl: RTL
====================

Name: boot_loader_ctl

Overview:
Serial boot controller for the microcomp board. It owns the SRAM bus and holds the CPU in reset after power-up. It loads program images from a byte stream supplied by the UART receive path and writes them into SRAM. On a "go" command it hands the bus back to the CPU and releases cpu_reset. It sits between the UART byte interface and the SRAM/CPU bus mux in the top level.

Parameters:
ADDR_WIDTH, 16, width of mem_addr (CPU address space)
TIMEOUT_CYCLES, 2080000, inter-byte timeout in CLK cycles (1 s at 2.08 MHz); minimum 2
TO_WIDTH, 24, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  response byte
tx_valid  out  1  response pending; held until tx_ready
tx_ready  in  1  UART transmitter accepts tx_data when tx_valid&tx_ready
mem_addr  out  ADDR_WIDTH  SRAM write address
mem_do  out  8  SRAM write data
mem_cs  out  1  SRAM chip select (write cycle)
mem_we  out  1  SRAM write enable
bus_grant  out  1  1 = loader drives SRAM bus, 0 = CPU drives it (mux select in top)
cpu_reset  out  1  active-high reset to CPU

Behaviour:
- Reset values: tx_data=0, tx_valid=0, mem_addr=0, mem_do=0, mem_cs=0, mem_we=0, bus_grant=1, cpu_reset=1. State=IDLE, counters=0. RESET in any state, including RUN or mid-load, returns all of these, so the CPU is re-held.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM, SEND, RUN.
- IDLE, on rx_valid:
  - 0x4C ('L') -> ADDR_HI.
  - 0x47 ('G') -> SEND with ACK (0x06), go flag set.
  - Any other byte -> SEND with NAK (0x15).
- ADDR_HI/ADDR_LO: latch address high/low byte. LEN: latch length byte; 0 means 256 bytes. Clear checksum accumulator, then -> DATA.
- DATA, per rx_valid:
  - The next cycle, mem_cs=mem_we=1 for exactly one cycle, with mem_addr=current address and mem_do=byte.
  - Address then increments modulo 2^ADDR_WIDTH; 0xFFFF wraps to 0x0000.
  - Checksum accumulator += byte, mod 256.
  - After the last byte -> CSUM.
- CSUM, on rx_valid: byte == accumulator -> SEND ACK, else -> SEND NAK. Written data is never rolled back.
- SEND:
  - tx_valid=1 with the response byte. Hold until tx_ready.
  - On handshake, tx_valid=0 the next cycle. Then -> RUN if go flag is set, else IDLE.
  - rx_valid bytes arriving in SEND are dropped.
- RUN: on ACK handshake for 'G', bus_grant=0 and cpu_reset=0 together, on the cycle after acceptance. In RUN, all rx bytes are ignored and mem_cs/mem_we stay 0. RUN exits only on RESET.
- Timeout:
  - Counter runs only in ADDR_HI, ADDR_LO, LEN, DATA and CSUM. It clears on every rx_valid and on state entry.
  - Reaching TIMEOUT_CYCLES -> SEND NAK, then IDLE.
  - Timeout and rx_valid in the same cycle: the byte wins and the counter clears.
- Latency from rx_valid of the final checksum byte to tx_valid=1 is one cycle.
- mem_cs/mem_we are never asserted outside DATA write cycles.
- bus_grant never drops while cpu_reset=1.

Test Plan:
- Reset -> cpu_reset=1, bus_grant=1, tx_valid=0, mem_we=0. Idle 100 cycles: no change.
- Send 4C 01 00 03 AA BB CC 31 -> writes AA@0x0100, BB@0x0101, CC@0x0102, one mem_we pulse each. Checksum 0x31 matches -> tx 0x06.
- Same stream with checksum 0x30 -> three writes still occur, tx 0x15, state back in IDLE. A following 'G' is accepted.
- Send 4C FF FF 02 11 22 33 -> writes 11@0xFFFF and 22@0x0000 (wrap), tx 0x06. Also: len=0x00 -> exactly 256 writes.
- TIMEOUT_CYCLES=50: send 4C 01 then silence -> tx 0x15 at cycle 50 after last byte. Next 'L' command completes normally. Unknown byte 0x7A in IDLE -> tx 0x15.
- Send 47 with tx_ready held 0 for 10 cycles -> tx_valid held with 0x06, cpu_reset stays 1. After handshake, cpu_reset=0 and bus_grant=0 the next cycle. Further rx ignored. RESET -> cpu_reset=1, bus_grant=1.

Source files
------------

// File: rtl/boot_loader_ctl_if.sv
// Loader-side bundle: UART byte stream in, response byte out, SRAM write port and CPU hand-off.
// master = boot_loader_ctl, slave = UART/SRAM/CPU side of the top-level mux.
interface boot_loader_ctl_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_do;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  bus_grant;
  logic                  cpu_reset;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, mem_addr, mem_do, mem_cs, mem_we, bus_grant, cpu_reset
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, mem_addr, mem_do, mem_cs, mem_we, bus_grant, cpu_reset
  );
endinterface

// File: rtl/boot_loader_ctl.sv
// Serial boot controller: holds the CPU in reset, loads checksummed images from the UART
// byte stream into SRAM, and hands the bus to the CPU on a 'G' command.
module boot_loader_ctl #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2080000,
  parameter int unsigned TO_WIDTH       = 24
) (
  input  logic              CLK,
  input  logic              RESET,
  boot_loader_ctl_if.master bus
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam int unsigned LEN_W   = 9;

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM, SEND, RUN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [7:0]            csum_q, csum_d;
  logic                  go_q, go_d;
  logic [TO_WIDTH-1:0]   to_q, to_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_do_q, mem_do_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  bus_grant_q, bus_grant_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  counting_c;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    csum_d      = csum_q;
    go_d        = go_q;
    to_d        = '0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_do_d    = mem_do_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    bus_grant_d = bus_grant_q;
    cpu_reset_d = cpu_reset_q;
    counting_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_LOAD: begin
              state_d = ADDR_HI;
              go_d    = 1'b0;
            end
            CMD_GO: begin
              state_d    = SEND;
              tx_data_d  = RSP_ACK;
              tx_valid_d = 1'b1;
              go_d       = 1'b1;
            end
            default: begin
              state_d    = SEND;
              tx_data_d  = RSP_NAK;
              tx_valid_d = 1'b1;
              go_d       = 1'b0;
            end
          endcase
        end
      end

      ADDR_HI: begin
        counting_c = 1'b1;
        if (bus.rx_valid) begin
          addr_d  = ADDR_WIDTH'({bus.rx_data, 8'h00});
          state_d = ADDR_LO;
        end
      end

      ADDR_LO: begin
        counting_c = 1'b1;
        if (bus.rx_valid) begin
          addr_d  = addr_q | ADDR_WIDTH'(bus.rx_data);
          state_d = LEN;
        end
      end

      LEN: begin
        counting_c = 1'b1;
        if (bus.rx_valid) begin
          // A zero length byte encodes a full 256-byte block
          len_d   = (bus.rx_data == 8'h00) ? LEN_W'(256) : LEN_W'(bus.rx_data);
          csum_d  = 8'h00;
          state_d = DATA;
        end
      end

      DATA: begin
        counting_c = 1'b1;
        if (bus.rx_valid) begin
          mem_cs_d   = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_do_d   = bus.rx_data;
          addr_d     = addr_q + ADDR_WIDTH'(1);
          csum_d     = csum_q + bus.rx_data;
          len_d      = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            state_d = CSUM;
          end
        end
      end

      CSUM: begin
        counting_c = 1'b1;
        if (bus.rx_valid) begin
          state_d    = SEND;
          tx_data_d  = (bus.rx_data == csum_q) ? RSP_ACK : RSP_NAK;
          tx_valid_d = 1'b1;
        end
      end

      SEND: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          if (go_q) begin
            state_d     = RUN;
            bus_grant_d = 1'b0;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      RUN: begin
        state_d = RUN;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Inter-byte timeout; a byte arriving on the expiry cycle takes priority
    if (counting_c && !bus.rx_valid) begin
      if (to_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
        state_d    = SEND;
        tx_data_d  = RSP_NAK;
        tx_valid_d = 1'b1;
      end else begin
        to_d = to_q + TO_WIDTH'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      go_q        <= 1'b0;
      to_q        <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_do_q    <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      bus_grant_q <= 1'b1;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      go_q        <= go_d;
      to_q        <= to_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_do_q    <= mem_do_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      bus_grant_q <= bus_grant_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_do    = mem_do_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.bus_grant = bus_grant_q;
  assign bus.cpu_reset = cpu_reset_q;

endmodule
